// File: rtl/div_sequencer.sv
// Iterative radix-2 restoring divide sequencer for DIV/DIVU/REM/REMU and W variants.
// One operation in flight; result is held in DONE until the consumer accepts it.
module div_sequencer #(
  parameter bit WORD_SHORTCUT = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  output logic        ready_out,
  input  logic [1:0]  op,
  input  logic        word,
  input  logic [63:0] src_a,
  input  logic [63:0] src_b,
  input  logic        flush,
  output logic        valid_out,
  input  logic        ready_in,
  output logic [63:0] result,
  output logic [1:0]  o_dbg_state
);

  // Handshake: a request transfers on a rising edge where valid_in && ready_out;
  // a result transfers on a rising edge where valid_out && ready_in.
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [6:0]  r_cnt;
  logic [63:0] r_rem;
  logic [63:0] r_dvd;
  logic [63:0] r_div;
  logic        r_sign_q;
  logic        r_sign_r;
  logic        r_is_rem;
  logic        r_word;
  logic        r_dz;
  logic [63:0] r_result;

  logic        w_signed;
  logic        w_short;
  logic        w_accept;
  logic [63:0] w_ext_a;
  logic [63:0] w_ext_b;
  logic        w_neg_a;
  logic        w_neg_b;
  logic [63:0] w_mag_a;
  logic [63:0] w_mag_b;
  logic        w_div_zero;
  logic [64:0] w_rem_sh;
  logic [64:0] w_diff;
  logic        w_ge;
  logic [63:0] w_q_fix;
  logic [63:0] w_r_fix;
  logic [63:0] w_sel;
  logic [63:0] w_fix_res;

  assign w_signed   = ~op[0];
  assign w_short    = word && WORD_SHORTCUT;
  assign w_ext_a    = !word ? src_a :
                      (w_signed ? {{32{src_a[31]}}, src_a[31:0]} : {32'h0, src_a[31:0]});
  assign w_ext_b    = !word ? src_b :
                      (w_signed ? {{32{src_b[31]}}, src_b[31:0]} : {32'h0, src_b[31:0]});
  assign w_neg_a    = w_signed & w_ext_a[63];
  assign w_neg_b    = w_signed & w_ext_b[63];
  assign w_mag_a    = w_neg_a ? (64'h0 - w_ext_a) : w_ext_a;
  assign w_mag_b    = w_neg_b ? (64'h0 - w_ext_b) : w_ext_b;
  assign w_div_zero = (w_ext_b == 64'h0);

  assign ready_out   = (r_state == S_IDLE) && !flush && !reset;
  assign w_accept    = valid_in && ready_out;
  assign valid_out   = (r_state == S_DONE);
  assign result      = r_result;
  assign o_dbg_state = r_state;

  // 65-bit partial remainder so a divisor above 2^63 still compares exactly.
  assign w_rem_sh = {r_rem, r_dvd[63]};
  assign w_diff   = w_rem_sh - {1'b0, r_div};
  assign w_ge     = w_rem_sh[64] | ~w_diff[64];

  assign w_q_fix   = r_sign_q ? (64'h0 - r_dvd) : r_dvd;
  assign w_r_fix   = r_sign_r ? (64'h0 - r_rem) : r_rem;
  assign w_sel     = r_dz ? (r_is_rem ? r_rem : 64'hFFFF_FFFF_FFFF_FFFF)
                          : (r_is_rem ? w_r_fix : w_q_fix);
  assign w_fix_res = r_word ? {{32{w_sel[31]}}, w_sel[31:0]} : w_sel;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = w_div_zero ? S_FIX : S_RUN;
      S_RUN:  if (r_cnt == 7'd1) w_next = S_FIX;
      S_FIX:  w_next = S_DONE;
      S_DONE: if (ready_in) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (flush) w_next = S_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= 7'd0;
      r_rem    <= 64'h0;
      r_dvd    <= 64'h0;
      r_div    <= 64'h0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_is_rem <= 1'b0;
      r_word   <= 1'b0;
      r_dz     <= 1'b0;
      r_result <= 64'h0;
    end else begin
      if (w_accept) begin
        // Word magnitudes fit in 32 bits, so pre-shifting skips 32 zero iterations.
        r_div    <= w_mag_b;
        r_dvd    <= w_short ? {w_mag_a[31:0], 32'h0} : w_mag_a;
        r_rem    <= w_div_zero ? w_ext_a : 64'h0;
        r_cnt    <= w_short ? 7'd32 : 7'd64;
        r_sign_q <= w_neg_a ^ w_neg_b;
        r_sign_r <= w_neg_a;
        r_is_rem <= op[1];
        r_word   <= word;
        r_dz     <= w_div_zero;
      end else if (r_state == S_RUN) begin
        r_rem <= w_ge ? w_diff[63:0] : w_rem_sh[63:0];
        r_dvd <= {r_dvd[62:0], w_ge};
        r_cnt <= r_cnt - 7'd1;
      end else if (r_state == S_FIX) begin
        r_result <= w_fix_res;
      end
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: directed literal cases plus random
// operations compared every cycle against an arithmetic reference model.
module tb_div_sequencer;

  localparam bit SHORTCUT = 1'b1;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic        ready_out;
  logic [1:0]  op;
  logic        word;
  logic [63:0] src_a;
  logic [63:0] src_b;
  logic        flush;
  logic        valid_out;
  logic        ready_in;
  logic [63:0] result;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state, advanced once per cycle by the compare process.
  logic        m_active = 1'b0;
  logic        m_done   = 1'b0;
  int          m_age;
  int          m_lat;
  logic [63:0] m_exp;
  logic [63:0] exp_q[$];

  div_sequencer #(.WORD_SHORTCUT(SHORTCUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .op         (op),
    .word       (word),
    .src_a      (src_a),
    .src_b      (src_b),
    .flush      (flush),
    .valid_out  (valid_out),
    .ready_in   (ready_in),
    .result     (result),
    .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] model_res(input logic [1:0] f_op, input logic f_word,
                                            input logic [63:0] a, input logic [63:0] b);
    logic sgn;
    logic [63:0] ea, eb, q, r, res;
    logic signed [63:0] sa, sb;
    sgn = (f_op == 2'd0) || (f_op == 2'd2);
    ea = a;
    eb = b;
    if (f_word) begin
      ea = sgn ? {{32{a[31]}}, a[31:0]} : {32'h0, a[31:0]};
      eb = sgn ? {{32{b[31]}}, b[31:0]} : {32'h0, b[31:0]};
    end
    if (eb == 64'h0) begin
      q = '1;
      r = ea;
    end else if (!sgn) begin
      q = ea / eb;
      r = ea % eb;
    end else if (ea == 64'h8000_0000_0000_0000 && eb == '1) begin
      q = ea;
      r = 64'h0;
    end else begin
      sa = ea;
      sb = eb;
      q = sa / sb;
      r = sa % sb;
    end
    res = f_op[1] ? r : q;
    if (f_word) res = {{32{res[31]}}, res[31:0]};
    return res;
  endfunction

  function automatic int model_lat(input logic [1:0] f_op, input logic f_word, input logic [63:0] b);
    logic [63:0] eb;
    eb = b;
    if (f_word) eb = f_op[0] ? {32'h0, b[31:0]} : {{32{b[31]}}, b[31:0]};
    if (eb == 64'h0) return 2;
    return (f_word && SHORTCUT) ? 34 : 66;
  endfunction

  // Compare process: every cycle, outputs against the model, then advance the model.
  always @(negedge clk) begin
    if (reset) begin
      chk("reset_valid_out", {63'h0, valid_out}, 64'h0);
      chk("reset_ready_out", {63'h0, ready_out}, 64'h0);
      chk("reset_result", result, 64'h0);
      m_active = 1'b0;
      m_done   = 1'b0;
      exp_q.delete();
    end else begin
      chk("valid_out", {63'h0, valid_out}, {63'h0, m_done});
      chk("ready_out", {63'h0, ready_out}, {63'h0, !m_active && !m_done && !flush});
      if (m_done) chk("result", result, m_exp);
      if (flush) begin
        m_active = 1'b0;
        m_done   = 1'b0;
        exp_q.delete();
      end else if (m_done) begin
        if (ready_in) m_done = 1'b0;
      end else if (m_active) begin
        m_age++;
        if (m_age == m_lat - 1) begin
          m_active = 1'b0;
          m_done   = 1'b1;
          m_exp    = exp_q.pop_front();
        end
      end else if (valid_in) begin
        exp_q.push_back(model_res(op, word, src_a, src_b));
        m_lat    = model_lat(op, word, src_b);
        m_age    = 0;
        m_active = 1'b1;
      end
    end
  end

  // Drivers start and end at posedge+1.
  task automatic accept_op(input logic [1:0] t_op, input logic t_word,
                           input logic [63:0] a, input logic [63:0] b);
    logic acc;
    acc = 1'b0;
    op = t_op; word = t_word; src_a = a; src_b = b; valid_in = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      acc = ready_out;
      @(posedge clk); #1;
      if (acc) break;
    end
    valid_in = 1'b0;
    if (!acc) chk("accept_timeout", 64'h0, 64'h1);
  endtask

  // Leaves the caller at the negedge where valid_out was first seen.
  task automatic wait_valid(output int lat);
    lat = -1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (valid_out) begin
        lat = k;
        break;
      end
      @(posedge clk); #1;
    end
    if (lat < 0) chk("valid_timeout", 64'h0, 64'h1);
  endtask

  task automatic run_dir(input string name, input logic [1:0] t_op, input logic t_word,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] exp_res, input int exp_lat);
    int lat;
    ready_in = 1'b1;
    accept_op(t_op, t_word, a, b);
    wait_valid(lat);
    chk({name, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({name, "_result"}, result, exp_res);
    @(posedge clk); #1;
  endtask

  function automatic logic [63:0] rand_operand();
    logic [63:0] v;
    case ($urandom_range(0, 5))
      0: v = {$urandom, $urandom};
      1: v = 64'($urandom_range(0, 20));
      2: v = 64'h0;
      3: v = 64'h8000_0000_0000_0000;
      4: v = {32'h0, $urandom};
      default: v = {32'h0, 32'h8000_0000};
    endcase
    if ($urandom_range(0, 1) == 1) v = 64'h0 - v;
    return v;
  endfunction

  task automatic rand_txn();
    logic fin;
    fin = 1'b0;
    ready_in = 1'b0;
    accept_op(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), rand_operand(), rand_operand());
    for (int c = 0; c < 200; c++) begin
      ready_in = ($urandom_range(0, 3) != 0);
      flush    = ($urandom_range(0, 149) == 0);
      @(negedge clk);
      if (flush || (valid_out && ready_in)) begin
        fin = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    flush = 1'b0;
    ready_in = 1'b0;
    if (!fin) chk("txn_timeout", 64'h0, 64'h1);
  endtask

  initial begin
    int lat;
    logic seen;
    reset = 1'b1; valid_in = 1'b0; op = 2'd0; word = 1'b0;
    src_a = 64'h0; src_b = 64'h0; flush = 1'b0; ready_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("init_state", {62'h0, dbg_state}, 64'h0);
    chk("init_valid_out", {63'h0, valid_out}, 64'h0);
    chk("init_ready_out", {63'h0, ready_out}, 64'h1);
    chk("init_result", result, 64'h0);
    @(posedge clk); #1;

    run_dir("div_neg7_2",  2'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66);
    run_dir("rem_neg7_2",  2'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66);
    run_dir("divu_by0",    2'd1, 1'b0, 64'h1234, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 2);
    run_dir("remu_by0",    2'd3, 1'b0, 64'h1234, 64'h0, 64'h1234, 2);
    run_dir("div_ovf",     2'd0, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 66);
    run_dir("rem_ovf",     2'd2, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h0, 66);
    run_dir("divw_ovf",    2'd0, 1'b1, 64'h0000_0000_8000_0000, '1, 64'hFFFF_FFFF_8000_0000, 34);
    run_dir("divuw",       2'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd2, 64'h0000_0000_7FFF_FFFF, 34);
    run_dir("remuw_by0",   2'd3, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_0000_0000,
            64'hFFFF_FFFF_8000_0000, 2);
    run_dir("divu_bigdiv", 2'd1, 1'b0, '1, 64'h8000_0000_0000_0001, 64'h1, 66);

    // Result held stable while the consumer stalls.
    ready_in = 1'b0;
    accept_op(2'd1, 1'b0, 64'd100, 64'd7);
    wait_valid(lat);
    chk("hold_latency", 64'(lat), 64'd66);
    repeat (10) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("hold_valid_out", {63'h0, valid_out}, 64'h1);
      chk("hold_result", result, 64'd14);
      chk("hold_ready_out", {63'h0, ready_out}, 64'h0);
    end
    @(posedge clk); #1;
    ready_in = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("hold_released", {63'h0, valid_out}, 64'h0);
    @(posedge clk); #1;

    // Flush in RUN cycle 20.
    accept_op(2'd0, 1'b0, 64'd1000, 64'd3);
    repeat (19) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_idle_state", {62'h0, dbg_state}, 64'h0);
    chk("flush_ready_out", {63'h0, ready_out}, 64'h1);
    seen = 1'b0;
    repeat (70) begin
      @(negedge clk);
      if (valid_out) seen = 1'b1;
    end
    chk("flush_no_valid", {63'h0, seen}, 64'h0);
    @(posedge clk); #1;

    // Reset mid-RUN clears outputs immediately.
    accept_op(2'd0, 1'b0, 64'd12345, 64'd6);
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("midrst_valid_out", {63'h0, valid_out}, 64'h0);
    chk("midrst_ready_out", {63'h0, ready_out}, 64'h0);
    chk("midrst_result", result, 64'h0);
    chk("midrst_state", {62'h0, dbg_state}, 64'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    for (int t = 0; t < 150; t++) rand_txn();

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, %0d checks %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
